// File: rtl/cam_frame_writer.sv
// Frame-buffer write controller for the OV7670 capture path: turns converted RGB332 pixels
// into row-major RAM writes, cropping to WIDTH x HEIGHT and reporting frame completion or truncation.
module cam_frame_writer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int AW     = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic          cont,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          px_valid,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    localparam logic [CW-1:0] COL_MAX   = CW'(WIDTH);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(HEIGHT);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
    localparam logic [RW:0]   LINES_REQ = (RW + 1)'(HEIGHT);
    localparam logic [RW:0]   LINES_ONE = (RW + 1)'(1);
    localparam logic [AW-1:0] LINE_STEP = AW'(WIDTH);

    logic [1:0]    state_r, state_s;
    logic          vs_q_r, hr_q_r;
    logic [CW-1:0] col_r, col_s;
    logic [RW-1:0] row_r, row_s;
    logic [AW-1:0] line_base_r, line_base_s;
    logic          line_active_r, line_active_s;
    logic          stop_r, stop_s;
    logic          single_done_r, single_done_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [7:0]    data_r, data_s;
    logic          we_r, we_s;
    logic          done_r, done_s;
    logic          err_r, err_s;
    logic          busy_r;
    logic [RW:0]   lines_seen_s;

    logic vs_fall_s, vs_rise_s, hr_rise_s;

    assign vs_fall_s = ~vsync & vs_q_r;
    assign vs_rise_s = vsync & ~vs_q_r;
    assign hr_rise_s = href & ~hr_q_r;

    // Next-state, line bookkeeping and write-request decode
    always_comb begin
        state_s       = state_r;
        col_s         = col_r;
        row_s         = row_r;
        line_base_s   = line_base_r;
        line_active_s = line_active_r;
        stop_s        = stop_r;
        single_done_s = single_done_r;
        addr_s        = addr_r;
        data_s        = data_r;
        we_s          = 1'b0;
        done_s        = 1'b0;
        err_s         = 1'b0;
        lines_seen_s  = '0;

        case (state_r)
            ST_IDLE: begin
                // A single-frame capture stays parked until cap_en is dropped and re-raised
                if (!cap_en) begin
                    single_done_s = 1'b0;
                end else if (!single_done_r) begin
                    state_s = ST_ARM;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ARM: begin
                if (!cap_en) begin
                    state_s = ST_IDLE;
                end else if (vs_fall_s) begin
                    state_s       = ST_FRAME;
                    col_s         = '0;
                    row_s         = '0;
                    line_base_s   = '0;
                    line_active_s = 1'b0;
                    stop_s        = 1'b0;
                end else begin
                    state_s = ST_ARM;
                end
            end

            ST_FRAME: begin
                stop_s = stop_r | ~cap_en;
                if (vs_rise_s) begin
                    if (line_active_r) begin
                        lines_seen_s = {1'b0, row_r} + LINES_ONE;
                    end else begin
                        lines_seen_s = '0;
                    end
                    if (lines_seen_s >= LINES_REQ) begin
                        done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    if (cont && cap_en && !stop_r) begin
                        state_s = ST_ARM;
                    end else begin
                        state_s       = ST_IDLE;
                        single_done_s = 1'b1;
                    end
                end else begin
                    if (hr_rise_s) begin
                        // Row stops advancing once past the buffer so line_base never overruns
                        if (line_active_r && (row_r < ROW_MAX)) begin
                            row_s       = row_r + ROW_ONE;
                            line_base_s = line_base_r + LINE_STEP;
                        end else begin
                            row_s       = row_r;
                            line_base_s = line_base_r;
                        end
                        line_active_s = 1'b1;
                        col_s         = '0;
                    end else begin
                        col_s = col_r;
                    end

                    if (px_valid && href && (row_s < ROW_MAX) && (col_s < COL_MAX)) begin
                        we_s   = 1'b1;
                        addr_s = line_base_s + AW'(col_s);
                        data_s = px_data;
                        col_s  = col_s + COL_ONE;
                    end else begin
                        we_s = 1'b0;
                    end
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered RAM/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            vs_q_r        <= 1'b1;
            hr_q_r        <= 1'b0;
            col_r         <= '0;
            row_r         <= '0;
            line_base_r   <= '0;
            line_active_r <= 1'b0;
            stop_r        <= 1'b0;
            single_done_r <= 1'b0;
            addr_r        <= '0;
            data_r        <= 8'h00;
            we_r          <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            vs_q_r        <= vsync;
            hr_q_r        <= href;
            col_r         <= col_s;
            row_r         <= row_s;
            line_base_r   <= line_base_s;
            line_active_r <= line_active_s;
            stop_r        <= stop_s;
            single_done_r <= single_done_s;
            addr_r        <= addr_s;
            data_r        <= data_s;
            we_r          <= we_s;
            done_r        <= done_s;
            err_r         <= err_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign mem_addr   = addr_r;
    assign mem_data   = data_r;
    assign mem_we     = we_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign frame_err  = err_r;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: directed frame shapes plus random frames, checked against a
// queue-based model of which (row, col) pixels land at row*WIDTH+col and which pulse each frame ends with.
module tb_cam_frame_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          cap_en;
    logic          cont;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic          px_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .cont       (cont),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: expected writes in order, expected end-of-frame pulses (1 = done, 2 = err)
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_data_q[$];
    int            exp_pulse_q[$];
    int            m_state = 0;   // 0 idle, 1 armed, 2 capturing
    bit            m_stop  = 1'b0;
    bit            m_hold  = 1'b0;

    logic [AW-1:0] log_addr[0:511];
    logic [7:0]    log_data[0:511];
    int            log_cyc[0:511];
    int            log_n    = 0;
    int            done_cnt = 0;
    int            err_cnt  = 0;

    int line_len[0:7];
    bit seq_mode = 1'b0;
    int seq_val  = 0;
    int first_px_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mon;
        int p;
        if (rst) begin
            if (mem_we) begin
                if (log_n < 512) begin
                    log_addr[log_n] = mem_addr;
                    log_data[log_n] = mem_data;
                    log_cyc[log_n]  = cyc;
                end
                log_n++;
                chk("addr_in_range", int'(int'(mem_addr) < W * H), 1);
                chk("write_expected", int'(exp_addr_q.size() != 0), 1);
                if (exp_addr_q.size() != 0) begin
                    chk("wr_addr", int'(mem_addr), int'(exp_addr_q.pop_front()));
                    chk("wr_data", int'(mem_data), int'(exp_data_q.pop_front()));
                end
            end
            chk("pulse_exclusive", int'(frame_done && frame_err), 0);
            if (frame_done || frame_err) begin
                if (frame_done) done_cnt++;
                if (frame_err) err_cnt++;
                chk("pulse_expected", int'(exp_pulse_q.size() != 0), 1);
                if (exp_pulse_q.size() != 0) begin
                    p = exp_pulse_q.pop_front();
                    chk("pulse_kind", frame_done ? 1 : 2, p);
                end
            end
        end
    endtask

    function automatic void model_cap(input bit v);
        if (v) begin
            if (m_state == 0 && !m_hold) m_state = 1;
        end else begin
            if (m_state == 2) m_stop = 1'b1;
            else begin
                m_state = 0;
                m_hold  = 1'b0;
            end
        end
    endfunction

    task automatic set_cap(input bit v);
        cap_en = v;
        model_cap(v);
        repeat (3) step;
    endtask

    // One camera frame: nl lines of line_len[] pixels; vs_px puts a pixel on the vsync-rise cycle
    task automatic frame(input int nl, input bit vs_px, input int drop_line);
        bit first;
        logic [7:0] d;
        first = 1'b1;
        vsync = 1'b1;
        step;
        step;
        vsync    = 1'b0;
        href     = 1'b0;
        px_valid = 1'b1;
        px_data  = 8'hEE;
        if (m_state == 1) begin
            m_state = 2;
            m_stop  = 1'b0;
        end
        step;
        px_valid = 1'b0;
        step;
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) begin
                cap_en = 1'b0;
                model_cap(1'b0);
            end
            href = 1'b1;
            if (line_len[l] == 0 || $urandom_range(0, 1) == 1) step;
            for (int p = 0; p < line_len[l]; p++) begin
                d = seq_mode ? 8'(seq_val) : 8'($urandom);
                seq_val++;
                px_valid = 1'b1;
                px_data  = d;
                if (first) begin
                    first_px_cyc = cyc;
                    first = 1'b0;
                end
                if (m_state == 2 && l < H && p < W) begin
                    exp_addr_q.push_back(AW'(l * W + p));
                    exp_data_q.push_back(d);
                end
                step;
                px_valid = 1'b0;
                if ($urandom_range(0, 3) == 0) step;
            end
            if (!(vs_px && l == nl - 1)) begin
                href = 1'b0;
                step;
                step;
            end
        end
        vsync = 1'b1;
        if (vs_px) begin
            px_valid = 1'b1;
            px_data  = 8'h5A;
        end
        if (m_state == 2) begin
            exp_pulse_q.push_back((nl >= H) ? 1 : 2);
            m_state = (cont && cap_en && !m_stop) ? 1 : 0;
            m_hold  = (m_state == 0) && cap_en;
            m_stop  = 1'b0;
        end
        step;
        px_valid = 1'b0;
        href     = 1'b0;
        repeat (4) step;
    endtask

    task automatic set_lines(input int a, input int b, input int c, input int d);
        line_len[0] = a;
        line_len[1] = b;
        line_len[2] = c;
        line_len[3] = d;
    endtask

    initial begin
        int b;
        int b2;
        int dc;
        int ec;
        int mx;
        rst      = 1'b0;
        cap_en   = 1'b0;
        cont     = 1'b0;
        vsync    = 1'b1;
        href     = 1'b0;
        px_valid = 1'b0;
        px_data  = 8'h00;
        for (int i = 0; i < 8; i++) line_len[i] = 0;

        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none

        repeat (3) step;
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(mem_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_err", int'(frame_err), 0);
        rst = 1'b1;
        repeat (3) step;
        chk("idle_busy", int'(busy), 0);

        // Nominal single frame with data 0x00..0x0B
        set_cap(1'b1);
        chk("arm_busy", int'(busy), 1);
        seq_mode = 1'b1;
        seq_val  = 0;
        b  = log_n;
        dc = done_cnt;
        set_lines(4, 4, 4, 0);
        frame(3, 1'b0, -1);
        seq_mode = 1'b0;
        chk("t1_count", log_n - b, 12);
        chk("t1_addr5", int'(log_addr[b + 5]), 5);
        chk("t1_data11", int'(log_data[b + 11]), 11);
        chk("t1_latency", log_cyc[b], first_px_cyc + 1);
        chk("t1_done", done_cnt - dc, 1);
        chk("t1_busy", int'(busy), 0);
        chk("t1_busy_model", int'(busy), int'(m_state != 0));
        set_cap(1'b0);
        set_cap(1'b1);

        // Oversize frame is cropped
        b  = log_n;
        dc = done_cnt;
        set_lines(6, 6, 6, 6);
        frame(4, 1'b0, -1);
        mx = 0;
        for (int i = b; i < log_n; i++) if (int'(log_addr[i]) > mx) mx = int'(log_addr[i]);
        chk("t2_count", log_n - b, 12);
        chk("t2_max", mx, 11);
        chk("t2_done", done_cnt - dc, 1);
        set_cap(1'b0);
        set_cap(1'b1);

        // Short middle line
        b  = log_n;
        dc = done_cnt;
        set_lines(4, 2, 4, 0);
        frame(3, 1'b0, -1);
        chk("t3_count", log_n - b, 10);
        chk("t3_addr4", int'(log_addr[b + 4]), 4);
        chk("t3_addr5", int'(log_addr[b + 5]), 5);
        chk("t3_addr8", int'(log_addr[b + 6]), 8);
        chk("t3_done", done_cnt - dc, 1);
        set_cap(1'b0);
        set_cap(1'b1);

        // Truncated frame, extra pixel on the vsync-rise cycle
        b  = log_n;
        dc = done_cnt;
        ec = err_cnt;
        set_lines(4, 4, 0, 0);
        frame(2, 1'b1, -1);
        chk("t4_count", log_n - b, 8);
        chk("t4_err", err_cnt - ec, 1);
        chk("t4_done", done_cnt - dc, 0);
        set_cap(1'b0);

        // Continuous: two frames, cap_en dropped during the second
        cont = 1'b1;
        set_cap(1'b1);
        b  = log_n;
        dc = done_cnt;
        set_lines(4, 4, 4, 0);
        frame(3, 1'b0, -1);
        b2 = log_n;
        frame(3, 1'b0, 1);
        chk("t5_count", b2 - b, 12);
        chk("t5_restart", int'(log_addr[b2]), 0);
        chk("t5_done", done_cnt - dc, 2);
        chk("t5_busy", int'(busy), 0);

        // Async reset mid-line, then pixels ignored until a fresh vsync fall
        set_cap(1'b1);
        vsync = 1'b1;
        step;
        step;
        vsync = 1'b0;
        if (m_state == 1) m_state = 2;
        step;
        step;
        href = 1'b1;
        step;
        px_valid = 1'b1;
        px_data  = 8'h11;
        exp_addr_q.push_back(AW'(0));
        exp_data_q.push_back(8'h11);
        step;
        px_data = 8'h22;
        #5;
        rst = 1'b0;
        #1;
        chk("rst_async_we", int'(mem_we), 0);
        chk("rst_async_busy", int'(busy), 0);
        px_valid = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_pulse_q.delete();
        m_state = 0;
        m_stop  = 1'b0;
        m_hold  = 1'b0;
        step;
        rst = 1'b1;
        model_cap(cap_en);
        step;
        b  = log_n;
        dc = done_cnt;
        ec = err_cnt;
        for (int i = 0; i < 3; i++) begin
            px_valid = 1'b1;
            px_data  = 8'($urandom);
            step;
        end
        px_valid = 1'b0;
        href = 1'b0;
        step;
        step;
        href = 1'b1;
        for (int i = 0; i < 2; i++) begin
            px_valid = 1'b1;
            step;
        end
        px_valid = 1'b0;
        href = 1'b0;
        step;
        vsync = 1'b1;
        repeat (3) step;
        chk("t6_ignored", log_n - b, 0);
        chk("t6_no_pulse", (done_cnt - dc) + (err_cnt - ec), 0);
        b = log_n;
        set_lines(4, 4, 4, 0);
        frame(3, 1'b0, -1);
        chk("t6_count", log_n - b, 12);
        chk("t6_first_addr", int'(log_addr[b]), 0);

        // Random frames in continuous mode
        for (int f = 0; f < 8; f++) begin
            int nl;
            nl = $urandom_range(1, 5);
            for (int l = 0; l < 8; l++) line_len[l] = $urandom_range(0, 6);
            frame(nl, 1'($urandom_range(0, 1)), -1);
        end

        set_cap(1'b0);
        repeat (6) step;
        chk("end_busy", int'(busy), 0);
        chk("left_writes", exp_addr_q.size(), 0);
        chk("left_pulses", exp_pulse_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Frame-buffer write controller sitting directly downstream of the RGB565→RGB332 byte converter in the OV7670 capture path. It takes converted 8-bit pixels with their write strobe, tracks frame and line boundaries from the camera VSYNC/HREF, and generates row-major addresses and write enables for the dual-port frame RAM. It crops oversize frames to the buffer geometry and reports frame completion and malformed frames.

## Interface
- WIDTH, 160: pixels per stored line.
- HEIGHT, 120: stored lines per frame.
- AW, 15: RAM address width; must satisfy 2^AW ≥ WIDTH*HEIGHT.
- clk  in  1  camera pixel clock (PCLK domain; converter runs on the same clock).
- rst  in  1  reset, asynchronous, active-low.
- cap_en  in  1  capture enable; level.
- cont  in  1  1 = capture every frame, 0 = single frame then stop.
- vsync  in  1  camera VSYNC, high during vertical blanking.
- href  in  1  camera HREF, high during active line.
- px_data  in  8  RGB332 pixel from converter.
- px_valid  in  1  one-cycle strobe, px_data valid.
- mem_addr  out  AW  RAM write address.
- mem_data  out  8  RAM write data.
- mem_we  out  1  RAM write enable, one cycle per write.
- busy  out  1  high in ARM or FRAME.
- frame_done  out  1  one-cycle pulse, complete frame stored.
- frame_err  out  1  one-cycle pulse, frame ended with fewer than HEIGHT lines.

## Operation
- vsync and href registered once (vs_q, hr_q) for edge detection; vs_fall = !vsync & vs_q, vs_rise = vsync & !vs_q, hr_rise = href & !hr_q.
- States: IDLE, ARM, FRAME.
- IDLE: outputs quiet; cap_en=1 → ARM.
- ARM: wait for vs_fall → FRAME, clear col=0, row=0, line_base=0, line_active=0. cap_en=0 → IDLE.
- FRAME:
  - hr_rise: if line_active was set in this frame, row++ and line_base += WIDTH (never multiply); set line_active=1, col=0.
  - px_valid & href & row<HEIGHT & col<WIDTH: write px_data at line_base+col, col++.
  - px_valid outside those conditions: dropped silently (crop; addresses never exceed WIDTH*HEIGHT-1).
  - Short line (< WIDTH pixels): remaining addresses of that row untouched; next line starts at next line_base.
  - vs_rise: lines_seen = row+1 if line_active else 0. lines_seen ≥ HEIGHT → frame_done; else frame_err. Then → ARM if cont & cap_en, else IDLE.
  - cap_en falling mid-frame: finish current frame (clean stop at vs_rise), then IDLE.
- Counters: col ⌈log2(WIDTH+1)⌉ bits, row ⌈log2(HEIGHT+1)⌉ bits, saturating at WIDTH/HEIGHT; line_base AW bits.

## Timing
- Reset (async assert, sync release): state=IDLE, mem_addr=0, mem_data=0, mem_we=0, busy=0, frame_done=0, frame_err=0, all counters 0, vs_q=1, hr_q=0.
- Write latency: px_valid in cycle N → mem_we=1, mem_addr, mem_data registered in cycle N+1. mem_addr/mem_data hold last value when mem_we=0.
- vs_fall in cycle N → FRAME from N+1; px_valid in same cycle as vs_fall is dropped.
- hr_rise and px_valid in same cycle: new line bookkeeping applies first; pixel written at new line_base+0.
- vs_rise and px_valid in same cycle: pixel dropped.
- frame_done/frame_err registered, asserted cycle after vs_rise; mutually exclusive.
- busy = (state≠IDLE), registered.
- Reset mid-frame: all writes stop immediately; no done/err pulse.

## Test plan
- WIDTH=4, HEIGHT=3, cont=0: vsync fall, 3 lines of 4 strobes (data 0x00..0x0B), vsync rise → addresses 0..11 written with matching data, one frame_done, return to IDLE, busy=0.
- Oversize frame: 4 lines of 6 pixels → only addresses 0..11 written (first 4 pixels of first 3 lines), no write ≥12, frame_done=1.
- Short line: line 1 has 2 pixels → writes at 4,5, then line 2 starts at addr 8; frame_done=1.
- Truncated frame: 2 lines then vsync rise → frame_err pulse, frame_done=0.
- cont=1, two back-to-back frames → two frame_done pulses, second frame restarts at addr 0; drop cap_en mid second frame → frame completes, then IDLE.
- Assert rst low mid-line → mem_we=0 asynchronously, state IDLE; after release pixels ignored until cap_en and a new vsync fall.
